// File: rtl/sr_command_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : sr_command_gen_if
// Brief    : Request inputs and command outputs of the SR command generator.
// Revision : 1.0
// ============================================================================
interface sr_command_gen_if;
    logic SET_IN;
    logic CLR_IN;
    logic S;
    logic R;
    logic CONFLICT;
    logic BUSY;

    modport master (
        output SET_IN,
        output CLR_IN,
        input  S,
        input  R,
        input  CONFLICT,
        input  BUSY
    );

    modport slave (
        input  SET_IN,
        input  CLR_IN,
        output S,
        output R,
        output CONFLICT,
        output BUSY
    );
endinterface
`default_nettype wire

// File: rtl/sr_command_gen.sv
`default_nettype none
// ============================================================================
// Module   : sr_command_gen
// Brief    : Synchronises and debounces raw set/clear requests and issues
//            rate-limited single-cycle S/R pulses for an SR flip-flop.
// Revision : 1.0
// ============================================================================
module sr_command_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLDOFF_CYCLES  = 3,
    parameter int unsigned CNT_W           = 3
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    sr_command_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_hold_last =
        CNT_W'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Channel 0 is set, channel 1 is clear.
    logic [1:0] w_raw;
    logic [1:0] w_req;

    assign w_raw = {bus.CLR_IN, bus.SET_IN};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic             r_sync1;
            logic             r_sync2;
            logic             r_deb;
            logic             r_deb_prev;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_sync1    <= 1'b0;
                    r_sync2    <= 1'b0;
                    r_deb      <= 1'b0;
                    r_deb_prev <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_sync1    <= w_raw[gi];
                    r_sync2    <= r_sync1;
                    r_deb_prev <= r_deb;
                    // Any sample matching the debounced level restarts the run.
                    if (r_sync2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_deb_last) begin
                        r_deb <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_req[gi] = r_deb & ~r_deb_prev;
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic             r_s;
    logic             r_r;
    logic             r_conflict;
    logic             w_s_nxt;
    logic             w_r_nxt;
    logic             w_conflict_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_s        <= w_s_nxt;
            r_r        <= w_r_nxt;
            r_conflict <= w_conflict_nxt;
        end
    end

    // Requests outside IDLE are dropped; the edge history keeps tracking so a
    // held input is not re-fired later.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_s_nxt        = 1'b0;
        w_r_nxt        = 1'b0;
        w_conflict_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req != 2'b00) begin
                    w_state_nxt    = ST_ISSUE;
                    w_s_nxt        = (w_req == 2'b01);
                    w_r_nxt        = (w_req == 2'b10);
                    w_conflict_nxt = (w_req == 2'b11);
                end
            end
            ST_ISSUE: begin
                w_hold_cnt_nxt = '0;
                w_state_nxt    = (HOLDOFF_CYCLES > 0) ? ST_HOLDOFF : ST_IDLE;
            end
            ST_HOLDOFF: begin
                if (r_hold_cnt == c_hold_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.S        = r_s;
    assign bus.R        = r_r;
    assign bus.CONFLICT = r_conflict;
    assign bus.BUSY     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sr_command_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_command_gen
// Brief    : Self-checking bench for sr_command_gen against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_sr_command_gen;

    localparam int DEB  = 4;
    localparam int HOLD = 3;
    localparam bit [31:0] MASK = (32'd1 << DEB) - 32'd1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    sr_command_gen_if ifc ();

    sr_command_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLDOFF_CYCLES (HOLD),
        .CNT_W          (3)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(ifc.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sync = 2-sample delay; a level flips once the last DEB synced
    // samples all disagree with it; a command occupies 1+HOLD busy cycles.
    bit [1:0]  m_s1, m_s2, m_d, m_dp;
    bit [31:0] m_hist [2];
    int        m_rem;
    bit        m_s, m_r, m_c;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_s1 <= '0; m_s2 <= '0; m_d <= '0; m_dp <= '0;
            m_hist[0] <= '0; m_hist[1] <= '0;
            m_rem <= 0; m_s <= 0; m_r <= 0; m_c <= 0;
        end else begin : mdl
            bit [31:0] h0, h1;
            bit [1:0]  req;
            h0 = {m_hist[0][30:0], m_s2[0]};
            h1 = {m_hist[1][30:0], m_s2[1]};
            m_hist[0] <= h0;
            m_hist[1] <= h1;
            m_s1 <= {ifc.CLR_IN, ifc.SET_IN};
            m_s2 <= m_s1;
            m_d[0] <= m_d[0] ^ ((h0 & MASK) == (m_d[0] ? 32'd0 : MASK));
            m_d[1] <= m_d[1] ^ ((h1 & MASK) == (m_d[1] ? 32'd0 : MASK));
            m_dp <= m_d;
            req = m_d & ~m_dp;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                m_s <= 0; m_r <= 0; m_c <= 0;
            end else begin
                m_s   <= (req == 2'b01);
                m_r   <= (req == 2'b10);
                m_c   <= (req == 2'b11);
                m_rem <= (req != 2'b00) ? HOLD + 1 : 0;
            end
        end
    end

    int cyc = 0;
    int last_pulse = -100;
    bit q_dut = 0, q_mdl = 0;

    always @(negedge CLK) begin
        if (RST) begin
            last_pulse = -100;
        end else begin
            cyc++;
            chk("S", int'(ifc.S), int'(m_s));
            chk("R", int'(ifc.R), int'(m_r));
            chk("CONFLICT", int'(ifc.CONFLICT), int'(m_c));
            chk("BUSY", int'(ifc.BUSY), int'(m_rem != 0));
            chk("S_and_R", int'(ifc.S & ifc.R), 0);
            chk("at_most_one", int'((32'(ifc.S) + 32'(ifc.R) + 32'(ifc.CONFLICT)) <= 1), 1);
            // One ISSUE cycle, HOLD holdoff cycles, then the IDLE edge.
            if (ifc.S || ifc.R || ifc.CONFLICT) begin
                chk("spacing", int'((cyc - last_pulse) >= HOLD + 2), 1);
                last_pulse = cyc;
            end
            if (ifc.S) q_dut = 1;
            if (ifc.R) q_dut = 0;
            if (m_s)   q_mdl = 1;
            if (m_r)   q_mdl = 0;
            chk("Q", int'(q_dut), int'(q_mdl));
        end
    end

    int fs, fr, fc, ns, nr, nc, nb;

    // Bit i of each pattern is the input level sampled at edge i+1.
    task automatic run(input int n, input bit [63:0] sp, input bit [63:0] cp);
        fs = 0; fr = 0; fc = 0; ns = 0; nr = 0; nc = 0; nb = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            ifc.SET_IN = sp[i];
            ifc.CLR_IN = cp[i];
            @(posedge CLK);
            #1;
            if (ifc.S)        begin ns++; if (fs == 0) fs = i + 1; end
            if (ifc.R)        begin nr++; if (fr == 0) fr = i + 1; end
            if (ifc.CONFLICT) begin nc++; if (fc == 0) fc = i + 1; end
            if (ifc.BUSY)     nb++;
        end
    endtask

    initial begin
        bit ts, tc;
        int rs, rr;
        ifc.SET_IN = 1'b0;
        ifc.CLR_IN = 1'b0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_S", int'(ifc.S), 0);
        chk("rst_R", int'(ifc.R), 0);
        chk("rst_CONFLICT", int'(ifc.CONFLICT), 0);
        chk("rst_BUSY", int'(ifc.BUSY), 0);
        @(negedge CLK);
        RST = 1'b0;

        // Held set request
        run(20, '1, '0);
        chk("s1_first_S", fs, 7);
        chk("s1_nS", ns, 1);
        chk("s1_nR", nr, 0);
        chk("s1_nC", nc, 0);
        chk("s1_busy", nb, 4);
        run(12, '0, '0);
        chk("s1_release_nS", ns, 0);
        chk("s1_release_busy", nb, 0);

        // Short glitch and bounce on clear, then a clean clear
        run(24, '0, 64'd839);
        chk("s2_glitch_nR", nr, 0);
        chk("s2_glitch_busy", nb, 0);
        run(10, '0, '1);
        chk("s2_first_R", fr, 7);
        chk("s2_nR", nr, 1);
        run(12, '0, '0);

        // Simultaneous requests
        run(20, '1, '1);
        chk("s3_first_C", fc, 7);
        chk("s3_nC", nc, 1);
        chk("s3_nS", ns, 0);
        chk("s3_nR", nr, 0);
        chk("s3_busy", nb, 4);
        run(12, '0, '0);

        // Clear request lands inside holdoff and is dropped
        run(20, '1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("s4_first_S", fs, 7);
        chk("s4_nS", ns, 1);
        chk("s4_nR", nr, 0);
        run(12, '0, '0);
        run(14, '0, '1);
        chk("s4_first_R", fr, 7);
        chk("s4_nR", nr, 1);
        run(12, '0, '0);

        // Asynchronous reset while busy, set held through release
        run(8, '1, '0);
        chk("s5_busy_before", int'(ifc.BUSY), 1);
        #2;
        RST = 1'b1;
        #1;
        chk("s5_S", int'(ifc.S), 0);
        chk("s5_R", int'(ifc.R), 0);
        chk("s5_CONFLICT", int'(ifc.CONFLICT), 0);
        chk("s5_BUSY", int'(ifc.BUSY), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        run(20, '1, '0);
        chk("s5_first_S", fs, 7);
        chk("s5_nS", ns, 1);
        run(12, '0, '0);

        // Random bouncing inputs
        ts = 0; tc = 0; rs = 0; rr = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 15) == 0) ts = ~ts;
            if ($urandom_range(0, 15) == 0) tc = ~tc;
            ifc.SET_IN = ts ^ ($urandom_range(0, 5) == 0);
            ifc.CLR_IN = tc ^ ($urandom_range(0, 5) == 0);
            @(posedge CLK);
            #1;
            if (ifc.S) rs++;
            if (ifc.R) rr++;
        end
        chk("s6_some_S", int'(rs > 0), 1);
        chk("s6_some_R", int'(rr > 0), 1);

        repeat (20) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr_command_gen.md
Name: sr_command_gen

Overview:
Upstream command stage for the SR flip-flop. It takes two raw, asynchronous, possibly bouncing request lines (set and clear), then synchronises and debounces them. From those it produces clean single-cycle S and R pulses that drive the flip-flop's S and R inputs directly. S and R are never asserted together; simultaneous requests are flagged instead of forwarded. A holdoff window after each issued command rate-limits the flip-flop.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from its debounced level before that level flips; legal range ≥1
HOLDOFF_CYCLES, 3, cycles after an issued command during which new requests are discarded; 0 = no holdoff
CNT_W, 3, counter width; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, HOLDOFF_CYCLES)

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous active-high reset
SET_IN  input  1  raw set request, asynchronous, may bounce
CLR_IN  input  1  raw clear request, asynchronous, may bounce
S  output  1  one-cycle set pulse to the SR flip-flop
R  output  1  one-cycle reset pulse to the SR flip-flop
CONFLICT  output  1  one-cycle pulse; set and clear requests arrived in the same cycle
BUSY  output  1  high while a command is issuing or in holdoff

Behaviour:
- Reset: clock is CLK; reset is RST, asynchronous and active-high.
  - RST=1 immediately clears every register: synchronisers, debounced levels, edge-detect history, counters.
  - State goes to IDLE. S=R=CONFLICT=BUSY=0.
  - Reset mid-ISSUE or mid-HOLDOFF aborts the operation with no further pulse.
- Synchroniser: a 2-FF chain per input gives signals set_s and clr_s.
- Debounce, per channel, with debounced level d and counter c:
  - set_s == d → c <= 0.
  - set_s != d and c == DEBOUNCE_CYCLES-1 → d <= set_s, c <= 0.
  - Otherwise → c <= c+1.
  - Any bounce back to d before terminal count restarts the count.
  - Both press and release are debounced.
- Edge detect: d_prev <= d every cycle in all states. The request is req = d & ~d_prev, a single cycle. Falling edges generate nothing.
- FSM states are IDLE, ISSUE and HOLDOFF.
  - IDLE, set_req only → ISSUE with S=1.
  - IDLE, clr_req only → ISSUE with R=1.
  - IDLE, both requests in the same cycle → ISSUE with CONFLICT=1 and S=R=0.
  - IDLE, no request → stay in IDLE.
  - ISSUE lasts exactly one cycle; outputs are registered. Exit goes to HOLDOFF if HOLDOFF_CYCLES>0, else to IDLE.
  - HOLDOFF lasts exactly HOLDOFF_CYCLES cycles, then returns to IDLE.
- Requests during ISSUE or HOLDOFF are discarded, not queued. Because d_prev keeps tracking, a held button is not re-fired; the user must release and re-press.
- BUSY = 1 in ISSUE and HOLDOFF, 0 in IDLE.
- Latency: SET_IN first sampled high at rising edge k and held steady. S is high for exactly one cycle, starting after edge k+DEBOUNCE_CYCLES+2 (the (DEBOUNCE_CYCLES+3)th sampling edge). The same latency applies to CLR_IN→R and to CONFLICT.
- Invariants: S&R is 0 at all times. At most one of S, R, CONFLICT is high in any cycle.
- Input held high through reset release: after RST deasserts, the synchronised and debounced path sees a fresh rising edge and issues one command with normal latency.

Test Plan:
Defaults for all scenarios: DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=3.
1. Reset, then SET_IN=1 for 20 cycles → S=1 for one cycle, starting after the 7th edge with SET_IN high. R=0 and CONFLICT=0 throughout. BUSY=1 for exactly 4 cycles, then 0. No second S while SET_IN is held.
2. CLR_IN glitches high for 3 cycles, also with bounce 1,0,1,1,0 → no R pulse, BUSY stays 0. A clean 10-cycle CLR_IN → one R pulse at the same latency as scenario 1.
3. SET_IN and CLR_IN rise on the same edge → CONFLICT=1 for one cycle, S=R=0, BUSY=1 for 4 cycles.
4. SET_IN press; CLR_IN rise timed so clr_req lands during HOLDOFF → S fires and R never fires. Release CLR_IN, re-press it after BUSY=0 → R fires once.
5. Assert RST asynchronously between clock edges while BUSY=1 → S, R, CONFLICT and BUSY all drop to 0 before the next edge. SET_IN held high across reset release → exactly one S, 7 edges after the first post-reset sampling edge.
6. 5000 cycles of random bouncing SET_IN/CLR_IN, with the outputs driving an SR flip-flop model → assert S&R==0 every cycle. The Q model matches the last issued S/R. Pulse spacing is ≥ HOLDOFF_CYCLES+1.
